// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: shares the single-port 256x8 RC4 S-array RAM between init, key-schedule and PRGA clients.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module s_mem_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int RD_LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CLIENTS-1:0]     req,
  input  logic [NUM_CLIENTS-1:0]     lock,
  input  logic [8*NUM_CLIENTS-1:0]   client_addr,
  input  logic [8*NUM_CLIENTS-1:0]   client_data,
  input  logic [NUM_CLIENTS-1:0]     client_wren,
  output logic [NUM_CLIENTS-1:0]     gnt,
  output logic [7:0]                 mem_address,
  output logic [7:0]                 mem_data,
  output logic                       mem_wren,
  input  logic [7:0]                 mem_q,
  output logic [7:0]                 q,
  output logic [NUM_CLIENTS-1:0]     rvalid
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] r_gnt;
  logic [IDX_W-1:0]       r_last;
  logic [NUM_CLIENTS-1:0] r_rd_pipe [RD_LATENCY];

  logic [NUM_CLIENTS-1:0] w_sel;
  logic [NUM_CLIENTS-1:0] w_gnt_next;
  logic [IDX_W-1:0]       w_last_next;
  logic                   w_hold;
  logic [NUM_CLIENTS-1:0] w_rd_tag;
  logic [7:0]             w_addr_term [NUM_CLIENTS];
  logic [7:0]             w_data_term [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] w_wren_term;

  // Per-client AND terms; the one-hot grant makes the OR below a clean mux.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_mux
      assign w_addr_term[gi] = {8{r_gnt[gi]}} & client_addr[8*gi +: 8];
      assign w_data_term[gi] = {8{r_gnt[gi]}} & client_data[8*gi +: 8];
      assign w_wren_term[gi] = r_gnt[gi] & req[gi] & client_wren[gi];
    end
  endgenerate

  always_comb begin
    mem_address = 8'h00;
    mem_data    = 8'h00;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      mem_address = mem_address | w_addr_term[i];
      mem_data    = mem_data    | w_data_term[i];
    end
  end

  assign mem_wren = |w_wren_term;
  assign gnt      = r_gnt;
  assign q        = mem_q;
  assign rvalid   = r_rd_pipe[RD_LATENCY-1];
  assign w_hold   = |(r_gnt & req & lock);
  assign w_rd_tag = r_gnt & req & ~client_wren;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    int idx;
    idx   = 0;
    w_sel = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      idx = (int'(r_last) + k) % NUM_CLIENTS;
      if (w_sel == '0 && req[idx]) begin
        w_sel[idx] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (w_sel == '0 && req[k]) begin
        w_sel[k] = 1'b1;
      end
    end
  end

  // The pointer is kept up to date so either build behaves the same if the option is flipped.
  logic w_unused_last;
  assign w_unused_last = ^r_last;
`endif

  assign w_gnt_next = w_hold ? r_gnt : w_sel;

  always_comb begin
    w_last_next = r_last;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_gnt_next[i]) begin
        w_last_next = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt  <= '0;
      r_last <= IDX_W'(NUM_CLIENTS - 1);
    end else begin
      r_gnt  <= w_gnt_next;
      r_last <= w_last_next;
    end
  end

  // Read-tag pipe matches the RAM read latency so rvalid lines up with mem_q.
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rd_pipe[gi] <= '0;
        end else if (gi == 0) begin
          r_rd_pipe[gi] <= w_rd_tag;
        end else begin
          r_rd_pipe[gi] <= r_rd_pipe[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: three instances (RD_LATENCY 1..3) share stimulus and a RAM; a
// transaction-level model predicts grants, mux outputs, rvalid timing and read data.
module tb_s_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  req, lock, client_wren;
  logic [23:0] client_addr, client_data;

  logic [2:0] gnt         [3];
  logic [7:0] mem_address [3];
  logic [7:0] mem_data    [3];
  logic       mem_wren    [3];
  logic [7:0] mem_q       [3];
  logic [7:0] q           [3];
  logic [2:0] rvalid      [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      s_mem_arbiter #(.NUM_CLIENTS(3), .RD_LATENCY(gi + 1)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .client_addr(client_addr), .client_data(client_data), .client_wren(client_wren),
        .gnt(gnt[gi]), .mem_address(mem_address[gi]), .mem_data(mem_data[gi]),
        .mem_wren(mem_wren[gi]), .mem_q(mem_q[gi]), .q(q[gi]), .rvalid(rvalid[gi])
      );
    end
  endgenerate

  // RAM with a registered read, delayed further for the longer-latency instances
  logic [7:0] ram [256] = '{default: 8'h00};
  logic [7:0] rdp [3];
  always @(posedge clk) begin
    if (mem_wren[0]) ram[mem_address[0]] <= mem_data[0];
    rdp[0] <= ram[mem_address[0]];
    rdp[1] <= rdp[0];
    rdp[2] <= rdp[1];
  end
  assign mem_q[0] = rdp[0];
  assign mem_q[1] = rdp[1];
  assign mem_q[2] = rdp[2];

  // Reference model state
  int         owner;
  int         last;
  int         cyc;
  int         wr_seen;
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [2:0] ring_rv [3][4];
  logic [7:0] ring_q  [3][4];
  int         n_pass = 0;
  int         n_total = 0;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
  endtask

  function automatic int arb(input logic [2:0] r, input int lst);
    if (r == 3'b000) return -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) if (r[(lst + k) % 3]) return (lst + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic step();
    logic [2:0] og, ng;
    logic       xfer, wr;
    logic [7:0] a, d;
    int         slot;
    #1;
    og   = (owner < 0) ? 3'b000 : 3'(1 << owner);
    a    = (owner < 0) ? 8'h00 : client_addr[owner*8 +: 8];
    d    = (owner < 0) ? 8'h00 : client_data[owner*8 +: 8];
    xfer = (owner >= 0) && req[owner];
    wr   = xfer && client_wren[owner];
    for (int g = 0; g < 3; g++) begin
      chk("mem_address", g, mem_address[g], a);
      chk("mem_data", g, mem_data[g], d);
      chk("mem_wren", g, mem_wren[g], wr);
    end
    if (mem_wren[0]) wr_seen++;
    if (reset) begin
      for (int l = 0; l < 3; l++) for (int s = 0; s < 4; s++) ring_rv[l][s] = 3'b000;
      owner = -1;
      last  = 2;
    end else begin
      if (xfer && !wr) begin
        for (int l = 0; l < 3; l++) begin
          slot = (cyc + 1 + l) % 4;
          ring_rv[l][slot] = ring_rv[l][slot] | og;
          ring_q[l][slot]  = ref_mem[a];
        end
      end
      if (!((owner >= 0) && req[owner] && lock[owner])) owner = arb(req, last);
      if (owner >= 0) last = owner;
    end
    if (wr) ref_mem[a] = d;
    @(posedge clk);
    #1;
    cyc++;
    ng = (owner < 0) ? 3'b000 : 3'(1 << owner);
    for (int g = 0; g < 3; g++) begin
      chk("gnt", g, gnt[g], ng);
      chk("rvalid", g, rvalid[g], ring_rv[g][cyc % 4]);
      if (ring_rv[g][cyc % 4] != 3'b000) chk("q", g, q[g], ring_q[g][cyc % 4]);
      ring_rv[g][cyc % 4] = 3'b000;
    end
  endtask

  logic [2:0] cont_exp [4];
  logic [7:0] op_a [4];
  logic [7:0] op_d [4];
  logic       op_w [4];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    cont_exp[0] = 3'b001; cont_exp[1] = 3'b010; cont_exp[2] = 3'b100; cont_exp[3] = 3'b001;
`else
    cont_exp[0] = 3'b001; cont_exp[1] = 3'b001; cont_exp[2] = 3'b001; cont_exp[3] = 3'b001;
`endif
    op_a[0] = 8'h10; op_d[0] = 8'h00; op_w[0] = 1'b0;
    op_a[1] = 8'h20; op_d[1] = 8'h00; op_w[1] = 1'b0;
    op_a[2] = 8'h20; op_d[2] = 8'hAA; op_w[2] = 1'b1;
    op_a[3] = 8'h10; op_d[3] = 8'hBB; op_w[3] = 1'b1;
    for (int l = 0; l < 3; l++) for (int s = 0; s < 4; s++) begin
      ring_rv[l][s] = 3'b000;
      ring_q[l][s]  = 8'h00;
    end
    owner = -1; last = 2; cyc = 0; wr_seen = 0;

    // Reset for two cycles with all clients requesting
    reset = 1'b1; req = 3'b111; lock = 3'b000; client_wren = 3'b000;
    client_addr = 24'h0; client_data = 24'h0;
    @(posedge clk);
    #1;
    step();
    chk("reset_gnt", 0, gnt[0], 3'b000);
    chk("reset_rvalid", 0, rvalid[0], 3'b000);
    chk("reset_wren", 0, mem_wren[0], 1'b0);

    // Contention with req=111 and no locks
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("contention", k, gnt[0], cont_exp[k]);
    end

    // Single writer sweeping the whole RAM
    req = 3'b001; client_wren = 3'b001; wr_seen = 0;
    for (int i = 0; i < 256; i++) begin
      client_addr[7:0] = 8'(i);
      client_data[7:0] = 8'(i);
      step();
      chk("sweep_gnt", i, gnt[0], 3'b001);
    end
    chk("sweep_writes", 0, wr_seen, 256);
    req = 3'b000; client_wren = 3'b000;
    step();
    chk("sweep_last", 0, ram[8'hFF], 8'hFF);
    chk("sweep_mid", 0, ram[8'h10], 8'h10);

    // Locked read-read-write-write swap by client 1 while client 2 requests
    req = 3'b110; lock = 3'b010;
    client_addr[15:8] = op_a[0]; client_data[15:8] = op_d[0]; client_wren[1] = op_w[0];
    client_addr[23:16] = 8'h55;
    step();
    chk("swap_grant", 0, gnt[0], 3'b010);
    for (int k = 0; k < 4; k++) begin
      client_addr[15:8] = op_a[k]; client_data[15:8] = op_d[k]; client_wren[1] = op_w[k];
      step();
      chk("swap_hold", k, gnt[0], 3'b010);
    end
    req = 3'b100; lock = 3'b000; client_wren = 3'b000;
    step();
    chk("swap_release", 0, gnt[0], 3'b100);
    req = 3'b000;
    for (int k = 0; k < 4; k++) step();
    chk("swap_ram20", 0, ram[8'h20], 8'hAA);
    chk("swap_ram10", 0, ram[8'h10], 8'hBB);

    // Reset during a locked sequence with reads in flight
    req = 3'b010; lock = 3'b010; client_addr[15:8] = 8'h30; client_wren = 3'b000;
    step();
    step();
    reset = 1'b1;
    step();
    for (int g = 0; g < 3; g++) begin
      chk("midrst_gnt", g, gnt[g], 3'b000);
      chk("midrst_rvalid", g, rvalid[g], 3'b000);
    end
    reset = 1'b0; req = 3'b000; lock = 3'b000;
    for (int k = 0; k < 4; k++) step();

    // Randomised traffic on a small address window to exercise read-after-write
    for (int k = 0; k < 400; k++) begin
      req         = 3'($urandom);
      lock        = 3'($urandom) & 3'($urandom);
      client_wren = 3'($urandom);
      for (int c = 0; c < 3; c++) begin
        client_addr[c*8 +: 8] = 8'($urandom_range(0, 15));
        client_data[c*8 +: 8] = 8'($urandom);
      end
      step();
    end
    req = 3'b000; lock = 3'b000;
    for (int k = 0; k < 4; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/s_mem_arbiter.md
# s_mem_arbiter

Three-client arbiter for the single-port 256x8 S-array RAM used by the RC4 decryption core. It shares the RAM between s_array_init (client 0), the key-scheduling swap loop (client 1) and the PRGA keystream loop (client 2). It issues one-hot grants, provides locked grants for the read-read-write-write swap sequences, and returns read data with per-client valid strobes. It sits between the three datapath FSMs and the RAM instance at the top level.

## Interface
Parameters:
- NUM_CLIENTS, 3, number of requesters; the design is fixed at 3, and the parameter exists only for vector sizing.
- RD_LATENCY, 1, cycles from a granted read until `mem_q` holds its data; legal values are 1–3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- req  in  3  per-client request; bit i belongs to client i.
- lock  in  3  per-client lock; holds the grant while req[i] and lock[i] are both high.
- client_addr  in  24  client i address at bits [8i+7:8i].
- client_data  in  24  client i write data at bits [8i+7:8i].
- client_wren  in  3  per-client write enable.
- gnt  out  3  registered one-hot grant (or zero).
- mem_address  out  8  to RAM address.
- mem_data  out  8  to RAM write data.
- mem_wren  out  1  to RAM write enable.
- mem_q  in  8  RAM read data.
- q  out  8  mem_q broadcast to all clients.
- rvalid  out  3  per-client read-data-valid strobe.

## Operation
- Access: a transfer happens in any cycle with gnt[i] & req[i].
  - mem_address, mem_data: combinational mux of the granted client's fields; 0 when gnt == 0.
  - mem_wren = client_wren[i] & req[i] & gnt[i].
- Grant hold (priority over arbitration): if gnt[i] & req[i] & lock[i] at an edge, gnt stays unchanged.
- Arbitration: otherwise gnt_next = select(req) per Configuration; gnt_next = 0 if req == 0.
- A lone requester stays granted every cycle, one transfer per cycle.
- Dropping req with lock still high releases the grant; lock without req is ignored.
- Read return: a granted read (req & gnt & ~client_wren) pushes a one-hot tag into an RD_LATENCY-deep shift pipe.
  - rvalid equals the pipe output.
  - q = mem_q, unregistered.
- Writes produce no rvalid.
- Round-robin pointer `last` records the most recently granted client. It updates whenever gnt_next != 0.

## Timing
- Reset values: gnt=000, rvalid=000, rvalid pipe cleared, last=2, mem_wren=0, mem_address=0, mem_data=0.
- Request-to-grant latency: req rising at edge N gives gnt at edge N+1; the first transfer occurs in cycle N+1.
- Release-to-next-grant latency: 1 cycle. There are no dead cycles between back-to-back grants to different clients.
- Read data: granted read in cycle C gives rvalid[i] and valid q in cycle C+RD_LATENCY.
- Multiple reads by the same client in consecutive cycles give consecutive rvalid pulses.
- Simultaneous requests: resolved in a single cycle, with exactly one bit of gnt set.
- Reset mid-operation:
  - gnt drops to 0 on the reset edge; a held lock does not survive reset.
  - In-flight rvalid tags are discarded.
- Changes to req during a locked grant by non-owners have no effect until release.
- Changing a client's addr, data or wren while granted takes effect in the same cycle (combinational path).

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - Search order starts at (last+1) mod 3 and wraps.
  - After client 2 the search order is 0, 1, 2.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, client 0 > client 1 > client 2.
  - `last` is still maintained but not used.
- Lock semantics are identical in both modes.

## Test plan
- Reset check: assert reset for 2 cycles with req=111 → gnt=000, mem_wren=0, rvalid=000.
  - Release reset → gnt=001 one cycle later (both modes, since last=2).
- Single writer: client 0 holds req=1, wren=1 and sweeps addr/data 0x00..0xFF → gnt[0] stays high.
  - mem_address == mem_data each cycle, 256 writes, and address 0xFF is written last.
- Locked swap: client 1 runs 4 accesses with lock=1 (read 0x10, read 0x20, write 0x20←0xAA, write 0x10←0xBB) while client 2 requests.
  - gnt stays 010 for all 4 cycles and switches to 100 the cycle after lock drops.
  - rvalid[1] pulses RD_LATENCY cycles after each read.
- Contention: req=111 held with lock=000.
  - With ARB_ROUND_ROBIN_EN: gnt cycles 001, 010, 100, 001.
  - Without it: gnt stays 001.
- Reset mid-lock: assert reset during client 1's locked sequence with a read in flight → gnt=000 and rvalid=000 the next cycle. No stale rvalid appears afterwards.
- Latency sweep: repeat the locked-swap test with RD_LATENCY=1, 2 and 3 → rvalid offset matches the parameter, and q matches the RAM model contents.
